// File: rtl/regfile_sync.sv
// Two-read / one-write register file with a power-up init sequencer that loads preset values.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a colliding read port.
module regfile_sync #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic              wr,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out1,
    output logic [DATA_W-1:0] data_out2,
    output logic              rd_valid,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] idx;
    logic              last_idx;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;

    function automatic logic [DATA_W-1:0] preset(input logic [ADDR_W-1:0] i);
        if (i == ADDR_W'(0)) return DATA_W'(1);
        if (i == ADDR_W'(1)) return DATA_W'(3);
        return '0;
    endfunction

    assign last_idx = (idx == ADDR_W'(DEPTH - 1));

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    if (last_idx) state_d = READY;
            READY:   state_d = READY;
            default: state_d = INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            idx     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT) idx <= idx + ADDR_W'(1);
        end
    end

    // Single write port shared by the init sequencer and user writes; user writes are dropped in INIT.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = data_in;
        if (!rst) begin
            if (state_q == INIT) begin
                mem_we    = 1'b1;
                mem_waddr = idx;
                mem_wdata = preset(idx);
            end else if (wr) begin
                mem_we = 1'b1;
            end
        end
    end

    // NOTE: the array has no reset; the init sequencer rewrites every entry after each reset instead.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_comb begin
        rdata1 = mem[addr1];
        rdata2 = mem[addr2];
`ifdef REGFILE_BYPASS_EN
        if (wr && (wr_addr == addr1)) rdata1 = data_in;
        if (wr && (wr_addr == addr2)) rdata2 = data_in;
`else
        // Collisions return the old value; the write lands at the same edge as the read capture.
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out1 <= '0;
            data_out2 <= '0;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if ((state_q == READY) && rd) begin
                data_out1 <= rdata1;
                data_out2 <= rdata2;
                rd_valid  <= 1'b1;
            end
        end
    end

    // Decoded straight from the state flop, so busy has no combinational path from any input.
    assign busy = (state_q == INIT);

endmodule

// File: tb/tb_regfile_sync.sv
// Scoreboard bench for regfile_sync: reads push expected data, a negedge monitor pops on rd_valid.
module tb_regfile_sync;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              rd;
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
    logic              wr;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out1;
    logic [DATA_W-1:0] data_out2;
    logic              rd_valid;
    logic              busy;

    typedef struct {
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   done     = 1'b0;

`ifdef REGFILE_BYPASS_EN
    localparam logic [DATA_W-1:0] COLLIDE_EXP = 8'h3C;
`else
    localparam logic [DATA_W-1:0] COLLIDE_EXP = 8'h00;
`endif

    regfile_sync #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd        (rd),
        .addr1     (addr1),
        .addr2     (addr2),
        .wr        (wr),
        .wr_addr   (wr_addr),
        .data_in   (data_in),
        .data_out1 (data_out1),
        .data_out2 (data_out2),
        .rd_valid  (rd_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (!done && rd_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rd_valid", 32'(rd_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("data_out1", 32'(data_out1), 32'(e.d1));
                check("data_out2", 32'(data_out2), 32'(e.d2));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2,
                           input logic [DATA_W-1:0] e1, input logic [DATA_W-1:0] e2);
        exp_t e;
        e.d1 = e1;
        e.d2 = e2;
        exp_q.push_back(e);
        rd    = 1'b1;
        addr1 = a1;
        addr2 = a2;
        step();
        rd = 1'b0;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr      = 1'b1;
        wr_addr = a;
        data_in = d;
        step();
        wr = 1'b0;
    endtask

    // Counts edges until busy falls; stray rd/wr driven during INIT are cleared once READY is seen.
    task automatic wait_ready(input string name);
        int n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        rd = 1'b0;
        wr = 1'b0;
        check(name, 32'(n), 32'd8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rd = 1'b0; wr = 1'b0;
        addr1 = '0; addr2 = '0; wr_addr = '0; data_in = '0;
        step();
        step();
        check("reset_data_out1", 32'(data_out1), 32'd0);
        check("reset_data_out2", 32'(data_out2), 32'd0);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd1);

        // Drop out of reset with a write and read pending throughout INIT; both must be ignored.
        rst = 1'b0;
        wr = 1'b1; wr_addr = 3'd4; data_in = 8'hFF;
        rd = 1'b1; addr1 = 3'd4; addr2 = 3'd4;
        wait_ready("init_busy_cycles");
        check("init_hold_data_out1", 32'(data_out1), 32'd0);

        do_read(3'd0, 3'd1, 8'h01, 8'h03);
        step();
        step();
        check("hold_data_out1", 32'(data_out1), 32'h01);
        check("hold_data_out2", 32'(data_out2), 32'h03);
        check("hold_rd_valid", 32'(rd_valid), 32'd0);

        do_write(3'd5, 8'hA5);
        do_read(3'd5, 3'd7, 8'hA5, 8'h00);
        do_read(3'd4, 3'd4, 8'h00, 8'h00);

        // Same-cycle write and read of r[2] on both ports.
        wr = 1'b1; wr_addr = 3'd2; data_in = 8'h3C;
        do_read(3'd2, 3'd2, COLLIDE_EXP, COLLIDE_EXP);
        wr = 1'b0;
        do_read(3'd2, 3'd2, 8'h3C, 8'h3C);

        // Write r[6] while reading other addresses in the same cycle.
        wr = 1'b1; wr_addr = 3'd6; data_in = 8'h5A;
        do_read(3'd0, 3'd5, 8'h01, 8'hA5);
        wr = 1'b0;
        do_read(3'd6, 3'd3, 8'h5A, 8'h00);

        do_write(3'd3, 8'h77);
        do_read(3'd3, 3'd3, 8'h77, 8'h77);
        step();

        // One-cycle reset with rd/wr asserted alongside; nothing may be issued.
        rst = 1'b1; rd = 1'b1; wr = 1'b1; wr_addr = 3'd3; data_in = 8'hEE;
        step();
        rst = 1'b0; rd = 1'b0; wr = 1'b0;
        check("rerst_data_out1", 32'(data_out1), 32'd0);
        check("rerst_data_out2", 32'(data_out2), 32'd0);
        check("rerst_busy", 32'(busy), 32'd1);
        wait_ready("rerst_busy_cycles");

        for (int i = 0; i < 4; i++) begin
            logic [DATA_W-1:0] e1;
            e1 = (i == 0) ? 8'h01 : (i == 1) ? 8'h03 : 8'h00;
            do_read(ADDR_W'(i), ADDR_W'(7 - i), e1, 8'h00);
        end
        step();
        step();
        step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
